// File: rtl/cu_pkg.sv
// Shared types and constants for the 8051 instruction-sequencing FSM:
// state encoding, supported opcodes, instruction length and class codes.
package cu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPND1  = 3'd3,
        S_OPND2  = 3'd4,
        S_EXEC   = 3'd5,
        S_WB     = 3'd6
    } state_t;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_MOV_A_IMM  = 8'h74;
    localparam logic [7:0] OP_ADD_A_IMM  = 8'h24;
    localparam logic [7:0] OP_MOV_A_DIR  = 8'hE5;
    localparam logic [7:0] OP_MOV_DIR_A  = 8'hF5;
    localparam logic [7:0] OP_MOV_RN_IMM = 8'h78;
    localparam logic [7:0] OP_MOV_RN_A   = 8'hF8;
    localparam logic [7:0] OP_MOV_DPTR   = 8'h90;
    localparam logic [7:0] OP_SJMP       = 8'h80;
    localparam logic [7:0] OP_JMP_A_DPTR = 8'h73;
    localparam logic [7:0] OP_RETI       = 8'h32;

    // Rn-form opcodes carry the register number in the low 3 bits
    localparam logic [7:0] RN_MASK = 8'hF8;

`ifdef CU_INTERRUPT_EN
    localparam logic INT_EN = 1'b1;
`else
    localparam logic INT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        LEN_1 = 2'd1,
        LEN_2 = 2'd2,
        LEN_3 = 2'd3
    } len_t;

    typedef enum logic [3:0] {
        CL_NOP     = 4'd0,
        CL_ACC_IMM = 4'd1,
        CL_RD_DIR  = 4'd2,
        CL_WR_DIR  = 4'd3,
        CL_WR_REG  = 4'd4,
        CL_DPTR    = 4'd5,
        CL_SJMP    = 4'd6,
        CL_JMP     = 4'd7,
        CL_RETI    = 4'd8
    } op_class_t;

    function automatic logic is_rn(input logic [7:0] op,
                                   input logic [7:0] base);
        return (op & RN_MASK) == base;
    endfunction

endpackage

// File: rtl/control_unit_opcode_decoder.sv
// Combinational opcode decoder.
// Ports: opcode in; len (1..3 bytes), op_class and legal out.
// RETI (0x32) is legal only when CU_INTERRUPT_EN is defined.
module opcode_decoder
    import cu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len,
    output logic [3:0] op_class,
    output logic       legal
);

    len_t      len_d;
    op_class_t cls_d;

    always_comb begin
        len_d = LEN_1;
        cls_d = CL_NOP;
        legal = 1'b1;
        unique case (1'b1)
            opcode == OP_NOP: begin
                cls_d = CL_NOP;
            end
            opcode == OP_MOV_A_IMM,
            opcode == OP_ADD_A_IMM: begin
                len_d = LEN_2;
                cls_d = CL_ACC_IMM;
            end
            opcode == OP_MOV_A_DIR: begin
                len_d = LEN_2;
                cls_d = CL_RD_DIR;
            end
            opcode == OP_MOV_DIR_A: begin
                len_d = LEN_2;
                cls_d = CL_WR_DIR;
            end
            is_rn(opcode, OP_MOV_RN_IMM): begin
                len_d = LEN_2;
                cls_d = CL_WR_REG;
            end
            is_rn(opcode, OP_MOV_RN_A): begin
                cls_d = CL_WR_REG;
            end
            opcode == OP_MOV_DPTR: begin
                len_d = LEN_3;
                cls_d = CL_DPTR;
            end
            opcode == OP_SJMP: begin
                len_d = LEN_2;
                cls_d = CL_SJMP;
            end
            opcode == OP_JMP_A_DPTR: begin
                cls_d = CL_JMP;
            end
            opcode == OP_RETI: begin
                cls_d = INT_EN ? CL_RETI : CL_NOP;
                legal = INT_EN;
            end
            default: begin
                // unsupported: run as a 1-byte NOP
                legal = 1'b0;
            end
        endcase
    end

    assign len      = len_d;
    assign op_class = cls_d;

endmodule

// File: rtl/control_unit.sv
// 8051 instruction-sequencing FSM driving the datapath control strobes.
// Ports: clock, reset (sync, active-low), opcode, data_vld, int_r in;
// rom/ir/pc/dptr/acc/alu/ram strobes, int_a, illegal_op out.
// Optional interrupt entry/RETI support: define CU_INTERRUPT_EN.
module control_unit
    import cu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       data_vld,
    input  logic       int_r,
    output logic       rom_en,
    output logic       ir_load_high,
    output logic       ir_load_low,
    output logic       pc_inc,
    output logic       pc_inc_offset,
    output logic       pc_set,
    output logic       dptr_load_high,
    output logic       dptr_load_low,
    output logic       acc_load,
    output logic       alu_en,
    output logic       ram_rd_en_reg,
    output logic       ram_wr_en_reg,
    output logic       ram_rd_en_data,
    output logic       ram_wr_en_data,
    output logic       ram_rd_en_sfr,
    output logic       ram_wr_en_sfr,
    output logic       int_a,
    output logic       illegal_op
);

    state_t    state;
    state_t    next;
    logic      opnd2_ld;
    logic [1:0] len_bits;
    logic [3:0] cls_bits;
    logic      legal;
    len_t      len;
    op_class_t cls;
    logic      int_take;

    opcode_decoder u_dec (
        .opcode   (opcode),
        .len      (len_bits),
        .op_class (cls_bits),
        .legal    (legal)
    );

    assign len = len_t'(len_bits);
    assign cls = op_class_t'(cls_bits);

`ifdef CU_INTERRUPT_EN
    logic in_service;

    // interrupt is only taken before the opcode byte is accepted
    assign int_take = (state == S_FETCH) && int_r && !in_service;

    always_ff @(posedge clock) begin
        if (!reset) begin
            in_service <= 1'b0;
        end else if (int_take) begin
            in_service <= 1'b1;
        end else if (state == S_EXEC && cls == CL_RETI) begin
            in_service <= 1'b0;
        end
    end
`else
    logic unused_int;
    assign unused_int = int_r;
    assign int_take   = 1'b0;
`endif

    // opnd2_ld is low in the first OPND2 cycle, which drives
    // dptr_load_high from the first operand instead of reading ROM
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            opnd2_ld <= 1'b0;
        end else begin
            state    <= next;
            opnd2_ld <= (state == S_OPND2);
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE: begin
                next = S_FETCH;
            end
            S_FETCH: begin
                if (!int_take && data_vld) next = S_DECODE;
            end
            S_DECODE: begin
                next = (len == LEN_1) ? S_EXEC : S_OPND1;
            end
            S_OPND1: begin
                if (data_vld) next = (len == LEN_3) ? S_OPND2 : S_EXEC;
            end
            S_OPND2: begin
                if (opnd2_ld && data_vld) next = S_EXEC;
            end
            S_EXEC: begin
                next = (cls == CL_RD_DIR) ? S_WB : S_FETCH;
            end
            S_WB: begin
                next = S_FETCH;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rom_en         = 1'b0;
        ir_load_high   = 1'b0;
        ir_load_low    = 1'b0;
        pc_inc         = 1'b0;
        pc_inc_offset  = 1'b0;
        pc_set         = 1'b0;
        dptr_load_high = 1'b0;
        dptr_load_low  = 1'b0;
        acc_load       = 1'b0;
        alu_en         = 1'b0;
        ram_rd_en_reg  = 1'b0;
        ram_wr_en_reg  = 1'b0;
        ram_rd_en_data = 1'b0;
        ram_wr_en_data = 1'b0;
        ram_rd_en_sfr  = 1'b0;
        ram_wr_en_sfr  = 1'b0;
        int_a          = 1'b0;
        illegal_op     = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (int_take) begin
                    int_a = 1'b1;
                end else begin
                    rom_en       = 1'b1;
                    ir_load_high = data_vld;
                    pc_inc       = data_vld;
                end
            end
            S_OPND1: begin
                rom_en      = 1'b1;
                ir_load_low = data_vld;
                pc_inc      = data_vld;
            end
            S_OPND2: begin
                if (!opnd2_ld) begin
                    dptr_load_high = 1'b1;
                end else begin
                    rom_en      = 1'b1;
                    ir_load_low = data_vld;
                    pc_inc      = data_vld;
                end
            end
            S_EXEC: begin
                illegal_op = !legal;
                unique case (cls)
                    CL_ACC_IMM: begin
                        alu_en   = 1'b1;
                        acc_load = 1'b1;
                    end
                    CL_RD_DIR: ram_rd_en_data = 1'b1;
                    CL_WR_DIR: ram_wr_en_data = 1'b1;
                    CL_WR_REG: ram_wr_en_reg  = 1'b1;
                    CL_DPTR:   dptr_load_low  = 1'b1;
                    CL_SJMP:   pc_inc_offset  = 1'b1;
                    CL_JMP:    pc_set         = 1'b1;
                    default: begin
                    end
                endcase
            end
            S_WB: begin
                // RAM read data arrives one cycle after the EXEC request
                ram_rd_en_data = 1'b1;
                acc_load       = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle vector table plus
// hand-written DPTR-load and interrupt sequences.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] opcode;
    logic       data_vld;
    logic       int_r;
    logic       rom_en, ir_load_high, ir_load_low, pc_inc;
    logic       pc_inc_offset, pc_set, dptr_load_high, dptr_load_low;
    logic       acc_load, alu_en, ram_rd_en_reg, ram_wr_en_reg;
    logic       ram_rd_en_data, ram_wr_en_data, ram_rd_en_sfr;
    logic       ram_wr_en_sfr, int_a, illegal_op;

    always #5 clock = ~clock;

    control_unit dut (
        .clock          (clock),
        .reset          (reset),
        .opcode         (opcode),
        .data_vld       (data_vld),
        .int_r          (int_r),
        .rom_en         (rom_en),
        .ir_load_high   (ir_load_high),
        .ir_load_low    (ir_load_low),
        .pc_inc         (pc_inc),
        .pc_inc_offset  (pc_inc_offset),
        .pc_set         (pc_set),
        .dptr_load_high (dptr_load_high),
        .dptr_load_low  (dptr_load_low),
        .acc_load       (acc_load),
        .alu_en         (alu_en),
        .ram_rd_en_reg  (ram_rd_en_reg),
        .ram_wr_en_reg  (ram_wr_en_reg),
        .ram_rd_en_data (ram_rd_en_data),
        .ram_wr_en_data (ram_wr_en_data),
        .ram_rd_en_sfr  (ram_rd_en_sfr),
        .ram_wr_en_sfr  (ram_wr_en_sfr),
        .int_a          (int_a),
        .illegal_op     (illegal_op)
    );

    logic [17:0] obs;
    assign obs = {rom_en, ir_load_high, ir_load_low, pc_inc,
                  pc_inc_offset, pc_set, dptr_load_high, dptr_load_low,
                  acc_load, alu_en, ram_rd_en_reg, ram_wr_en_reg,
                  ram_rd_en_data, ram_wr_en_data, ram_rd_en_sfr,
                  ram_wr_en_sfr, int_a, illegal_op};

    localparam logic [17:0] NONE = 18'h00000;
    localparam logic [17:0] R    = 18'h20000;
    localparam logic [17:0] IRH  = 18'h10000;
    localparam logic [17:0] IRL  = 18'h08000;
    localparam logic [17:0] PCI  = 18'h04000;
    localparam logic [17:0] PCO  = 18'h02000;
    localparam logic [17:0] PCS  = 18'h01000;
    localparam logic [17:0] DPH  = 18'h00800;
    localparam logic [17:0] DPL  = 18'h00400;
    localparam logic [17:0] ACC  = 18'h00200;
    localparam logic [17:0] ALU  = 18'h00100;
    localparam logic [17:0] WRR  = 18'h00040;
    localparam logic [17:0] RDD  = 18'h00020;
    localparam logic [17:0] WRD  = 18'h00010;
    localparam logic [17:0] INTA = 18'h00002;
    localparam logic [17:0] ILL  = 18'h00001;
    localparam logic [17:0] FB   = R | IRH | PCI;
    localparam logic [17:0] OB   = R | IRL | PCI;

`ifdef CU_INTERRUPT_EN
    localparam logic [17:0] RETI_EX = NONE;
`else
    localparam logic [17:0] RETI_EX = ILL;
`endif

    typedef struct {
        string       tag;
        logic        rst;
        logic        dv;
        logic [7:0]  rb;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   excl   = 0;

    function automatic void add(input string t, input logic rst,
                                input logic dv, input logic [7:0] rb,
                                input logic [17:0] e);
        vec_t v;
        v.tag = t;
        v.rst = rst;
        v.dv  = dv;
        v.rb  = rb;
        v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [17:0] act,
                         input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_n(input string name, input int act,
                           input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // one clock: drive, sample mid-cycle, then update the IR model
    task automatic step(input logic rst, input logic dv,
                        input logic irq, input logic [7:0] rb,
                        output logic [17:0] o);
        reset    = rst;
        data_vld = dv;
        int_r    = irq;
        @(negedge clock);
        o = obs;
        if ((32'(o[14]) + 32'(o[13]) + 32'(o[12])) > 1) excl++;
        @(posedge clock);
        #1;
        if (o[16]) opcode = rb;
    endtask

    logic [17:0] o;
    logic [7:0]  rom [0:7];
    int          pc;
    int          n_pci, n_dph, n_dpl, at_dph, at_dpl;

    initial begin
        reset    = 1'b0;
        data_vld = 1'b0;
        int_r    = 1'b0;
        opcode   = 8'h00;
        repeat (2) @(posedge clock);
        #1;

        add("rst_hold",  0, 0, 8'h00, NONE);
        add("idle",      1, 1, 8'h00, NONE);
        add("74_fetch",  1, 1, 8'h74, FB);
        add("74_decode", 1, 1, 8'h5A, NONE);
        add("74_opnd1",  1, 1, 8'h5A, OB);
        add("74_exec",   1, 1, 8'h00, ALU | ACC);
        add("e5_wait0",  1, 0, 8'hE5, R);
        add("e5_wait1",  1, 0, 8'hE5, R);
        add("e5_fetch",  1, 1, 8'hE5, FB);
        add("e5_decode", 1, 0, 8'h30, NONE);
        add("e5_wait2",  1, 0, 8'h30, R);
        add("e5_wait3",  1, 0, 8'h30, R);
        add("e5_opnd1",  1, 1, 8'h30, OB);
        add("e5_exec",   1, 1, 8'h00, RDD);
        add("e5_wb",     1, 1, 8'h00, RDD | ACC);
        add("a5_fetch",  1, 1, 8'hA5, FB);
        add("a5_decode", 1, 1, 8'h00, NONE);
        add("a5_exec",   1, 1, 8'h00, ILL);
        add("80_fetch",  1, 1, 8'h80, FB);
        add("80_decode", 1, 1, 8'hFE, NONE);
        add("80_opnd1",  1, 1, 8'hFE, OB);
        add("80_exec",   1, 1, 8'h00, PCO);
        add("73_fetch",  1, 1, 8'h73, FB);
        add("73_decode", 1, 1, 8'h00, NONE);
        add("73_exec",   1, 1, 8'h00, PCS);
        add("7a_fetch",  1, 1, 8'h7A, FB);
        add("7a_decode", 1, 1, 8'h11, NONE);
        add("7a_opnd1",  1, 1, 8'h11, OB);
        add("7a_exec",   1, 1, 8'h00, WRR);
        add("f9_fetch",  1, 1, 8'hF9, FB);
        add("f9_decode", 1, 1, 8'h00, NONE);
        add("f9_exec",   1, 1, 8'h00, WRR);
        add("00_fetch",  1, 1, 8'h00, FB);
        add("00_decode", 1, 1, 8'h00, NONE);
        add("00_exec",   1, 1, 8'h00, NONE);
        add("32_fetch",  1, 1, 8'h32, FB);
        add("32_decode", 1, 1, 8'h00, NONE);
        add("32_exec",   1, 1, 8'h00, RETI_EX);
        add("f5_fetch",  1, 1, 8'hF5, FB);
        add("f5_decode", 1, 1, 8'h33, NONE);
        add("f5_opnd1",  1, 1, 8'h33, OB);
        add("f5_exec",   0, 1, 8'h00, WRD);
        add("f5_rst2",   0, 1, 8'h00, NONE);
        add("f5_idle",   1, 1, 8'h00, NONE);
        add("refetch",   1, 0, 8'h00, R);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].dv, 1'b0, tbl[i].rb, o);
            check(tbl[i].tag, o, tbl[i].exp);
        end

        // 90 12 34 from a small ROM model, zero wait states
        rom[0] = 8'h90; rom[1] = 8'h12; rom[2] = 8'h34; rom[3] = 8'h00;
        rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'h00;
        step(0, 0, 0, 8'h00, o);
        step(1, 0, 0, 8'h00, o);
        pc = 0; n_pci = 0; n_dph = 0; n_dpl = 0;
        at_dph = -1; at_dpl = -1;
        for (int c = 0; c < 6; c++) begin
            step(1, 1, 0, rom[pc[2:0]], o);
            if (o[14]) begin
                pc++;
                n_pci++;
            end
            if (o[11]) begin
                n_dph++;
                at_dph = c;
            end
            if (o[10]) begin
                n_dpl++;
                at_dpl = c;
            end
        end
        check_n("dptr_pc_inc", n_pci, 3);
        check_n("dptr_hi_cnt", n_dph, 1);
        check_n("dptr_lo_cnt", n_dpl, 1);
        check_n("dptr_hi_cyc", at_dph, 3);
        check_n("dptr_lo_cyc", at_dpl, 5);
        step(1, 1, 0, rom[pc[2:0]], o);
        check("dptr_next_fetch", o, FB);

        // interrupt raised mid-instruction of 24 01, then RETI
        step(0, 0, 0, 8'h00, o);
        step(1, 0, 0, 8'h00, o);
`ifdef CU_INTERRUPT_EN
        step(1, 1, 0, 8'h24, o);
        check("irq_24_fetch", o, FB);
        step(1, 1, 1, 8'h01, o);
        check("irq_24_decode", o, NONE);
        step(1, 1, 1, 8'h01, o);
        check("irq_24_opnd1", o, OB);
        step(1, 1, 1, 8'h00, o);
        check("irq_24_exec", o, ALU | ACC);
        step(1, 1, 1, 8'h32, o);
        check("irq_take", o, INTA);
        step(1, 1, 1, 8'h32, o);
        check("irq_ignored", o, FB);
        step(1, 1, 1, 8'h00, o);
        check("reti_decode", o, NONE);
        step(1, 1, 1, 8'h00, o);
        check("reti_exec", o, NONE);
        step(1, 1, 1, 8'h00, o);
        check("irq_retake", o, INTA);
`else
        step(1, 1, 1, 8'h24, o);
        check("noirq_24_fetch", o, FB);
        step(1, 1, 1, 8'h01, o);
        check("noirq_24_decode", o, NONE);
        step(1, 1, 1, 8'h01, o);
        check("noirq_24_opnd1", o, OB);
        step(1, 1, 1, 8'h00, o);
        check("noirq_24_exec", o, ALU | ACC);
        step(1, 1, 1, 8'h00, o);
        check("noirq_fetch", o, FB);
`endif

        check_n("pc_strobe_excl", excl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
